// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one single-port SRAM between fetch and data requesters.
//   Fixed data priority, with a starvation guard that lets fetch win after
//   MAX_STARVE consecutive lost cycles. Responses return one cycle after
//   acceptance and go to the requester that issued the access.
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   inst_*              fetch request (req/addr) and response (addr_ok/data_ok/rdata)
//   data_*              data request (req/wr/wstrb/addr/wdata) and response
//   sram_*              SRAM drive (en/we/addr/wdata) and read data return
module sram_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MAX_STARVE = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                inst_req,
    input  logic [ADDR_W-1:0]   inst_addr,
    output logic                inst_addr_ok,
    output logic                inst_data_ok,
    output logic [DATA_W-1:0]   inst_rdata,
    input  logic                data_req,
    input  logic                data_wr,
    input  logic [DATA_W/8-1:0] data_wstrb,
    input  logic [ADDR_W-1:0]   data_addr,
    input  logic [DATA_W-1:0]   data_wdata,
    output logic                data_addr_ok,
    output logic                data_data_ok,
    output logic [DATA_W-1:0]   data_rdata,
    output logic                sram_en,
    output logic [DATA_W/8-1:0] sram_we,
    output logic [ADDR_W-1:0]   sram_addr,
    output logic [DATA_W-1:0]   sram_wdata,
    input  logic [DATA_W-1:0]   sram_rdata
);
    typedef enum logic [1:0] {NONE = 2'd0, INST = 2'd1, DATA = 2'd2} owner_t;
    owner_t     owner, owner_nxt;
    logic [3:0] starve_cnt, starve_nxt;
    logic       inst_win, data_win, starved;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner      <= NONE;
            starve_cnt <= '0;
        end else begin
            owner      <= owner_nxt;
            starve_cnt <= starve_nxt;
        end
    end
    always_comb begin
        starved    = starve_cnt == 4'(MAX_STARVE);
        inst_win   = ~reset & inst_req & (~data_req | starved);
        data_win   = ~reset & data_req & ~inst_win;
        owner_nxt  = inst_win ? INST : data_win ? DATA : NONE;
        // A waiting fetch only loses to a data grant, so counting data wins
        // while fetch is pending counts exactly the cycles fetch lost.
        starve_nxt = (inst_win | ~inst_req) ? 4'd0
                   : (data_win & ~starved) ? starve_cnt + 4'd1 : starve_cnt;
    end
    assign inst_addr_ok = inst_win;
    assign data_addr_ok = data_win;
    assign sram_en      = inst_win | data_win;
    assign sram_we      = (data_win & data_wr) ? data_wstrb : '0;
    assign sram_addr    = inst_win ? inst_addr : data_addr;
    assign sram_wdata   = data_wdata;
    assign inst_data_ok = ~reset & (owner == INST);
    assign data_data_ok = ~reset & (owner == DATA);
    assign inst_rdata   = sram_rdata;
    assign data_rdata   = sram_rdata;
endmodule

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Shares one single-port synchronous SRAM between the instruction-fetch requester and the data-access requester. Arbitrates every cycle with fixed data priority and a starvation guard for fetch. Routes each one-cycle-latency response back to the requester that issued it. Sits between the pipeline front/memory stages and the unified instruction/data SRAM.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width; strobe width is DATA_W/8
- MAX_STARVE, 4, consecutive lost cycles after which fetch wins; legal range 1..15

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high
- inst_req  in  1  fetch request valid
- inst_addr  in  ADDR_W  fetch address
- inst_addr_ok  out  1  fetch request accepted this cycle
- inst_data_ok  out  1  fetch response valid
- inst_rdata  out  DATA_W  fetch read data
- data_req  in  1  data request valid
- data_wr  in  1  1 = write, 0 = read
- data_wstrb  in  DATA_W/8  byte write enables
- data_addr  in  ADDR_W  data address
- data_wdata  in  DATA_W  write data
- data_addr_ok  out  1  data request accepted this cycle
- data_data_ok  out  1  data response valid; read data, or write completion
- data_rdata  out  DATA_W  data read data
- sram_en  out  1  SRAM access this cycle
- sram_we  out  DATA_W/8  byte write enables; 0 for reads
- sram_addr  out  ADDR_W  SRAM address
- sram_wdata  out  DATA_W  SRAM write data
- sram_rdata  in  DATA_W  valid the cycle after an access with sram_en=1

## Operation
- State:
  - `owner`: 2-bit encoding NONE/INST/DATA; identifies the access issued last cycle.
  - `starve_cnt`: 4-bit counter.
- Grant, combinational, at most one per cycle; both grants are 0 while reset is high:
  - inst_win = inst_req & (~data_req | starve_cnt == MAX_STARVE)
  - data_win = data_req & ~inst_win
- Handshakes:
  - inst_addr_ok = inst_win; data_addr_ok = data_win.
  - A request is consumed on a cycle where req & addr_ok.
  - Requesters hold req, addr, wr, wstrb and wdata stable until they see addr_ok.
- SRAM drive:
  - sram_en = inst_win | data_win.
  - sram_addr and sram_wdata come from the winner. With no winner they come from data, and their value is don't-care.
  - sram_we = data_win & data_wr ? data_wstrb : 0. Fetch never writes.
- Owner update at each edge:
  - INST if inst_win; DATA if data_win; otherwise NONE.
- Response:
  - inst_data_ok = (owner == INST); data_data_ok = (owner == DATA).
  - inst_rdata = data_rdata = sram_rdata, driven combinationally.
  - Requesters must accept data_ok unconditionally. There is no response backpressure.
- Starvation counter update at each edge:
  - cleared when inst_win or ~inst_req;
  - incremented when inst_req & data_win;
  - saturates at MAX_STARVE.
- Writes return data_data_ok one cycle after acceptance. data_rdata is don't-care for writes.

## Timing
- Reset values: owner=NONE, starve_cnt=0.
- While reset is high: all *_addr_ok, *_data_ok, sram_en and sram_we are 0.
- Request to addr_ok: 0 cycles, combinational.
- Acceptance at edge t gives data_ok during cycle t+1. Fixed 1-cycle latency.
- Throughput is one access per cycle. Back-to-back accesses overlap: data_ok for the access at t coincides with addr_ok for the access at t+1.
- Both requesting, counter below MAX_STARVE: data wins; fetch waits.
- Counter reaches MAX_STARVE: fetch wins on the next contested cycle; the counter then clears.
- Sustained contention therefore gives fetch exactly 1 grant per MAX_STARVE+1 cycles.
- Reset asserted while an access is outstanding:
  - owner is forced to NONE immediately and asynchronously;
  - the pending data_ok is dropped;
  - no response follows reset release.
- First grant possible in the first cycle after reset deasserts.

## Test plan
- Reset: assert reset mid-stream with owner=DATA -> data_data_ok drops to 0 in the same cycle. After release, no data_ok appears until a new request.
- Fetch only: inst_req=1 for 3 cycles, addresses 0x1c000000, +4, +8; SRAM model returns addr^0xFFFF -> inst_addr_ok=1 every cycle. inst_data_ok=1 in cycles 2-4 with matching rdata.
- Data write then read: write 0xDEADBEEF to 0x100 with wstrb=0xF, then read 0x100 -> sram_we=0xF, then sram_we=0. data_data_ok pulses on both following cycles. The read returns 0xDEADBEEF.
- Byte write: wstrb=0x2, wdata=0x0000AB00 to a word holding 0x11223344 -> a subsequent read returns 0x1122AB44.
- Contention with MAX_STARVE=4: both req held 10 cycles -> data granted cycles 0-3, inst cycle 4, data 5-8, inst 9. Responses route to the correct requester.
- Simultaneous events: inst grant in the same cycle as data_data_ok for the previous data read -> both outputs correct, with no cross-routing.
